// File: rtl/conv_acc_top.sv
// APB slave that convolves a 28x28 unsigned 8-bit image with a 3x3 kernel
// (zero-padded correlation) and serves the 20-bit results from a result RAM.
module conv_acc_top #(
   parameter int unsigned IMG_W = 28,
   parameter int unsigned K_W   = 3,
   parameter int unsigned DW    = 8,
   parameter int unsigned RW    = 20
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [12:0] PADDR,
   input  logic [31:0] PWDATA,
   input  logic        PWRITE,
   input  logic        PSEL,
   input  logic        PENABLE,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR
);
   localparam int unsigned NPIX = IMG_W * IMG_W;
   localparam int unsigned NK   = K_W * K_W;
   localparam int unsigned PW   = $clog2(NPIX);
   localparam int unsigned KPW  = $clog2(NK);
   localparam int unsigned CW   = $clog2(IMG_W);
   localparam int unsigned MW   = 2 * DW;

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_e;

   state_e         state_q;
   logic           en_q;
   logic [KPW-1:0] a_ptr_q;
   logic [PW-1:0]  x_ptr_q;
   logic [PW-1:0]  r_ptr_q;
   logic [PW-1:0]  out_idx_q;
   logic [CW-1:0]  row_q;
   logic [CW-1:0]  col_q;

   logic [DW-1:0]  a_mem [NK];
   logic [DW-1:0]  x_mem [NPIX];
   logic [RW-1:0]  r_mem [NPIX];

   logic access_c, sel_ctrl_c, sel_a_c, sel_x_c, sel_res_c;
   logic err_c, stall_c, xfer_c, busy_c, done_c;
   logic a_fire_c, x_fire_c, rd_fire_c, comp_step_c, last_x_c;
   logic [RW-1:0] acc_c;
   logic [MW-1:0] prod_c;
   int            rr_c, cc_c;
   logic          unused_ok_c;

   assign unused_ok_c = ^PWDATA[31:DW];

   // Address decode and error classification
   assign access_c   = PSEL && PENABLE;
   assign sel_ctrl_c = (PADDR == 13'd0);
   assign sel_a_c    = (PADDR == 13'd1);
   assign sel_x_c    = (PADDR == 13'd2);
   assign sel_res_c  = (PADDR == 13'd3);
   assign err_c      = (PADDR > 13'd3) || (PWRITE && sel_res_c) ||
                       (!PWRITE && (sel_a_c || sel_x_c));
   assign busy_c     = (state_q == COMPUTE);
   assign done_c     = (state_q == DONE);

   // Loads wait out a compute; result reads wait until the addressed word exists
   assign stall_c = !err_c && busy_c &&
                    ((PWRITE && (sel_a_c || sel_x_c)) ||
                     (!PWRITE && sel_res_c && (r_ptr_q >= out_idx_q)));

   assign xfer_c      = access_c && !stall_c;
   assign PREADY      = xfer_c;
   assign PSLVERR     = access_c && err_c;
   assign a_fire_c    = xfer_c && PWRITE && sel_a_c && en_q;
   assign x_fire_c    = xfer_c && PWRITE && sel_x_c && en_q;
   assign rd_fire_c   = xfer_c && !PWRITE && sel_res_c;
   assign comp_step_c = busy_c && en_q;
   assign last_x_c    = (x_ptr_q == PW'(NPIX - 1));

   always_comb begin
      PRDATA = '0;
      if (xfer_c && !PWRITE) begin
         if (sel_ctrl_c)
            PRDATA = {29'd0, done_c, busy_c, en_q};
         else if (sel_res_c)
            PRDATA = 32'(r_mem[r_ptr_q]);
      end
   end

   // Nine parallel MACs for the current output pixel, zero outside the image
   always_comb begin
      acc_c  = '0;
      prod_c = '0;
      rr_c   = 0;
      cc_c   = 0;
      for (int i = 0; i < int'(K_W); i++) begin
         for (int j = 0; j < int'(K_W); j++) begin
            rr_c   = int'(row_q) + i - 1;
            cc_c   = int'(col_q) + j - 1;
            prod_c = '0;
            if (rr_c >= 0 && rr_c < int'(IMG_W) && cc_c >= 0 && cc_c < int'(IMG_W))
               prod_c = MW'(a_mem[KPW'(i * int'(K_W) + j)]) *
                        MW'(x_mem[PW'(rr_c * int'(IMG_W) + cc_c)]);
            acc_c = acc_c + RW'(prod_c);
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) begin
         state_q   <= IDLE;
         en_q      <= 1'b0;
         a_ptr_q   <= '0;
         x_ptr_q   <= '0;
         r_ptr_q   <= '0;
         out_idx_q <= '0;
         row_q     <= '0;
         col_q     <= '0;
      end else begin
         if (xfer_c && PWRITE && sel_ctrl_c)
            en_q <= PWDATA[0];
         if (rd_fire_c)
            r_ptr_q <= (r_ptr_q == PW'(NPIX - 1)) ? '0 : r_ptr_q + PW'(1);
         if (a_fire_c)
            a_ptr_q <= (a_ptr_q == KPW'(NK - 1)) ? '0 : a_ptr_q + KPW'(1);
         if (x_fire_c)
            x_ptr_q <= last_x_c ? '0 : x_ptr_q + PW'(1);

         case (state_q)
            IDLE, LOAD, DONE: begin
               if (x_fire_c && last_x_c) begin
                  state_q   <= COMPUTE;
                  out_idx_q <= '0;
                  row_q     <= '0;
                  col_q     <= '0;
                  r_ptr_q   <= '0;
               end else if (a_fire_c || x_fire_c) begin
                  state_q <= LOAD;
               end
            end
            COMPUTE: begin
               // EN low freezes the sweep in place
               if (en_q) begin
                  out_idx_q <= out_idx_q + PW'(1);
                  if (col_q == CW'(IMG_W - 1)) begin
                     col_q <= '0;
                     row_q <= row_q + CW'(1);
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
                  if (out_idx_q == PW'(NPIX - 1))
                     state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Storage arrays carry no reset
   always_ff @(posedge HCLK) begin
      if (a_fire_c)
         a_mem[a_ptr_q] <= PWDATA[DW-1:0];
      if (x_fire_c)
         x_mem[x_ptr_q] <= PWDATA[DW-1:0];
      if (comp_step_c)
         r_mem[out_idx_q] <= acc_c;
   end

endmodule

// File: tb/tb_conv_acc_top.sv
// Scoreboard bench for conv_acc_top: loads kernels/images over APB and checks
// every returned result against a reference correlation computed here.
module tb_conv_acc_top;
   localparam int NPIX     = 784;
   localparam int WAIT_MAX = 2000;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [12:0] PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int n_cmp = 0;
   int n_bad = 0;

   int unsigned a_m   [9];
   int unsigned x_m   [NPIX];
   int unsigned exp_r [NPIX];
   int unsigned got_r [NPIX];
   int unsigned exp_q [$];

   logic [31:0] rd;
   logic        err;
   int          w;
   int          ready_seen;

   conv_acc_top dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PWRITE  (PWRITE),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One APB transfer, entered just after a rising edge; bounded wait on PREADY
   task automatic apb_xfer(input logic [12:0] addr, input logic wr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic perr, output int waits);
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      waits = 0;
      @(negedge HCLK);
      while (!PREADY && waits < WAIT_MAX) begin
         waits++;
         @(negedge HCLK);
      end
      if (!PREADY) chk($sformatf("timeout_addr%0d", addr), {31'd0, PREADY}, 32'd1);
      rdata = PRDATA;
      perr  = PSLVERR;
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic status(input string tag, input logic [31:0] exp);
      logic [31:0] d; logic e; int ww;
      apb_xfer(13'd0, 1'b0, 32'd0, d, e, ww);
      chk(tag, d, exp);
   endtask

   task automatic compute_golden();
      for (int r = 0; r < 28; r++)
         for (int c = 0; c < 28; c++) begin
            int unsigned s = 0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++) begin
                  int rr = r + i - 1;
                  int cc = c + j - 1;
                  if (rr >= 0 && rr < 28 && cc >= 0 && cc < 28)
                     s += a_m[i*3+j] * x_m[rr*28+cc];
               end
            exp_r[r*28+c] = s;
         end
   endtask

   task automatic load_case(input int mode);
      logic [31:0] d; logic e; int ww;
      for (int i = 0; i < 9; i++)
         case (mode)
            0:       a_m[i] = 1;
            3:       a_m[i] = 255;
            default: a_m[i] = (i == 4) ? 1 : 0;
         endcase
      for (int k = 0; k < NPIX; k++)
         case (mode)
            0:       x_m[k] = 1;
            1:       x_m[k] = k % 256;
            2:       x_m[k] = (k + 37) % 256;
            default: x_m[k] = 255;
         endcase
      compute_golden();
      for (int i = 0; i < 9; i++) apb_xfer(13'd1, 1'b1, a_m[i], d, e, ww);
      for (int k = 0; k < NPIX; k++) apb_xfer(13'd2, 1'b1, x_m[k], d, e, ww);
   endtask

   task automatic read_results(input int from, input int upto);
      logic [31:0] d; logic e; int ww;
      int unsigned ex;
      for (int k = from; k < upto; k++) begin
         exp_q.push_back(exp_r[k]);
         apb_xfer(13'd3, 1'b0, 32'd0, d, e, ww);
         ex = exp_q.pop_front();
         got_r[k] = d;
         chk($sformatf("res[%0d]", k), d, ex);
      end
   endtask

   task automatic wait_done();
      logic [31:0] d; logic e; int ww;
      d = '0;
      for (int n = 0; n < 1000 && !d[2]; n++) apb_xfer(13'd0, 1'b0, 32'd0, d, e, ww);
      chk("done_status", d, 32'd5);
   endtask

   task automatic try_stalled_read(input int n, output int seen);
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 13'd3; PWRITE = 1'b0; PWDATA = '0;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge HCLK);
         if (PREADY) seen++;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge HCLK); #1;
   endtask

   initial begin
      HRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1'b0;
      @(negedge HCLK);
      chk("idle_prdata", PRDATA, 32'd0);
      chk("idle_pready", {31'd0, PREADY}, 32'd0);
      chk("idle_pslverr", {31'd0, PSLVERR}, 32'd0);
      @(posedge HCLK); #1;

      apb_xfer(13'd0, 1'b0, 32'd0, rd, err, w);
      chk("reset_status", rd, 32'd0);
      chk("reset_status_err", {31'd0, err}, 32'd0);

      // Error decode
      apb_xfer(13'd5, 1'b1, 32'd1, rd, err, w);
      chk("wr5_err", {31'd0, err}, 32'd1);
      apb_xfer(13'd5, 1'b0, 32'd0, rd, err, w);
      chk("rd5_err", {31'd0, err}, 32'd1);
      chk("rd5_data", rd, 32'd0);
      apb_xfer(13'd2, 1'b0, 32'd0, rd, err, w);
      chk("rd2_err", {31'd0, err}, 32'd1);
      chk("rd2_data", rd, 32'd0);
      apb_xfer(13'd3, 1'b1, 32'd7, rd, err, w);
      chk("wr3_err", {31'd0, err}, 32'd1);
      status("after_err_status", 32'd0);

      // Loads with EN=0 must not move pointers or leave IDLE
      apb_xfer(13'd1, 1'b1, 32'd99, rd, err, w);
      apb_xfer(13'd2, 1'b1, 32'd99, rd, err, w);
      status("en0_status", 32'd0);
      apb_xfer(13'd0, 1'b1, 32'd1, rd, err, w);
      status("en1_status", 32'd1);

      // Case 0: all ones
      load_case(0);
      status("busy_status", 32'd3);
      wait_done();
      read_results(0, NPIX);
      chk("ones_corner0", got_r[0], 32'd4);
      chk("ones_corner783", got_r[783], 32'd4);
      chk("ones_edge1", got_r[1], 32'd6);
      chk("ones_edge28", got_r[28], 32'd6);
      chk("ones_interior29", got_r[29], 32'd9);

      // Case 1/2: identity kernel, two images
      load_case(1);
      wait_done();
      read_results(0, NPIX);
      load_case(2);
      read_results(0, NPIX);
      status("case2_done", 32'd5);

      // Case 3: saturation values, with a frozen compute to expose the read stall
      load_case(3);
      apb_xfer(13'd0, 1'b1, 32'd0, rd, err, w);
      status("frozen_status", 32'd2);
      read_results(0, 2);
      try_stalled_read(6, ready_seen);
      chk("rd_stall_held", ready_seen, 32'd0);
      apb_xfer(13'd0, 1'b1, 32'd1, rd, err, w);
      read_results(2, NPIX);
      wait_done();
      chk("max_corner", got_r[0], 32'd260100);
      chk("max_edge", got_r[1], 32'd390150);
      chk("max_interior", got_r[29], 32'd585225);

      // Case 4: kernel write during compute stalls until done, then clears done
      load_case(0);
      apb_xfer(13'd1, 1'b1, 32'd7, rd, err, w);
      chk("wr_stall_long", {31'd0, (w > 700)}, 32'd1);
      status("after_stalled_wr", 32'd1);
      read_results(0, NPIX);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
